// File: rtl/multi_digit_counter_hex_pkg.sv
// Shared constants for the multi-digit counter: digit width, count modes
// and the active-low 7-segment lookup table (bit order gfedcba).
package multi_digit_counter_hex_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_UP   = 2'b01;
    localparam logic [1:0] MODE_DOWN = 2'b10;
    localparam logic [1:0] MODE_ROT  = 2'b11;

    // Entry n is the active-low pattern for hex digit n; listed F down to 0
    // so that SEG_TABLE[n] selects digit n.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

endpackage

// File: rtl/multi_digit_counter_hex_count_prescaler.sv
// Free-running prescaler: counts 0..TICK_DIV-1 and wraps; tick is high for
// the whole cycle in which the count sits at TICK_DIV-1. clr restarts the
// phase at 0 so the next tick is a full period away.
module count_prescaler #(
    parameter int TICK_DIV = 50000000
) (
    input  logic clk_50m,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int              CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0]   LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;

    // Next count: clear or wrap to 0, otherwise advance by one.
    always_comb begin
        count_next = count_reg;
        if (clr || (count_reg == LAST)) begin
            count_next = '0;
        end else begin
            count_next = count_reg + CW'(1);
        end
    end

    // Prescaler phase register.
    always_ff @(posedge clk_50m) begin
        if (rst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign tick = (count_reg == LAST);

endmodule

// File: rtl/multi_digit_counter_hex.sv
// DIGITS-nibble loadable up/down/rotate counter stepping on a prescaled tick,
// with one static active-low 7-segment display per nibble.
// Optional macro MULTI_DIGIT_COUNTER_BCD_EN: per-digit decimal up/down
// counting with carry/borrow between digits and load-time clamping to 9.
module multi_digit_counter_hex
    import multi_digit_counter_hex_pkg::*;
#(
    parameter int DIGITS   = 2,
    parameter int TICK_DIV = 50000000
) (
    input  logic                  clk_50m,
    input  logic                  rst,
    input  logic                  load_en,
    input  logic [4*DIGITS-1:0]   in,
    input  logic [1:0]            cnt,
    output logic [4*DIGITS-1:0]   value,
    output logic                  tick,
    output logic                  wrap,
    output logic [7*DIGITS-1:0]   hex
);

    localparam int W = DIGITS * DIGIT_W;

    logic [W-1:0] value_reg;
    logic [W-1:0] value_next;
    logic         wrap_reg;
    logic         wrap_next;

    logic [W-1:0] load_value;
    logic [W-1:0] inc_value;
    logic [W-1:0] dec_value;
    logic [W-1:0] rot_value;
    logic         inc_wrap;
    logic         dec_wrap;

    // A load restarts the prescaler so the next step is a full period later.
    count_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk_50m (clk_50m),
        .rst     (rst),
        .clr     (load_en),
        .tick    (tick)
    );

`ifdef MULTI_DIGIT_COUNTER_BCD_EN
    // Decimal ripple: chain bit gi is high when digit gi must change.
    logic [DIGITS:0] carry_chain;
    logic [DIGITS:0] borrow_chain;

    assign carry_chain[0]  = 1'b1;
    assign borrow_chain[0] = 1'b1;

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_bcd
        logic [DIGIT_W-1:0] digit;
        logic [DIGIT_W-1:0] in_digit;

        assign digit    = value_reg[gi*DIGIT_W +: DIGIT_W];
        assign in_digit = in[gi*DIGIT_W +: DIGIT_W];

        assign load_value[gi*DIGIT_W +: DIGIT_W] = (in_digit > 4'd9) ? 4'd9 : in_digit;

        assign inc_value[gi*DIGIT_W +: DIGIT_W] =
            !carry_chain[gi] ? digit : ((digit >= 4'd9) ? 4'd0 : digit + 4'd1);
        assign carry_chain[gi+1] = carry_chain[gi] && (digit >= 4'd9);

        assign dec_value[gi*DIGIT_W +: DIGIT_W] =
            !borrow_chain[gi] ? digit : ((digit == 4'd0) ? 4'd9 : digit - 4'd1);
        assign borrow_chain[gi+1] = borrow_chain[gi] && (digit == 4'd0);
    end

    assign inc_wrap = carry_chain[DIGITS];
    assign dec_wrap = borrow_chain[DIGITS];
`else
    assign load_value = in;
    assign inc_value  = value_reg + W'(1);
    assign dec_value  = value_reg - W'(1);
    assign inc_wrap   = &value_reg;
    assign dec_wrap   = ~|value_reg;
`endif

    // Rotate left by one digit; a single digit has nothing to rotate.
    if (DIGITS > 1) begin : g_rot
        assign rot_value = {value_reg[W-DIGIT_W-1:0], value_reg[W-1:W-DIGIT_W]};
    end else begin : g_no_rot
        assign rot_value = value_reg;
    end

    // Next value/wrap: load wins over a tick; cnt only matters on a tick.
    always_comb begin
        value_next = value_reg;
        wrap_next  = 1'b0;
        if (load_en) begin
            value_next = load_value;
        end else if (tick) begin
            case (cnt)
                MODE_UP: begin
                    value_next = inc_value;
                    wrap_next  = inc_wrap;
                end
                MODE_DOWN: begin
                    value_next = dec_value;
                    wrap_next  = dec_wrap;
                end
                MODE_ROT: begin
                    value_next = rot_value;
                end
                default: begin
                    value_next = value_reg;
                end
            endcase
        end
    end

    // Count and wrap registers.
    always_ff @(posedge clk_50m) begin
        if (rst) begin
            value_reg <= '0;
            wrap_reg  <= 1'b0;
        end else begin
            value_reg <= value_next;
            wrap_reg  <= wrap_next;
        end
    end

    assign value = value_reg;
    assign wrap  = wrap_reg;

    // Per-digit segment decode straight from the registered value.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_seg
        assign hex[7*gi +: 7] = SEG_TABLE[value_reg[gi*DIGIT_W +: DIGIT_W]];
    end

endmodule
